evt_count_sched: RTL and testbench

Round-robin scheduler that shares a single x-pulse counting engine (a modulo event counter of the kind used in our sequence-detect FSMs) among NREQ requesters. Each requester asks for a counting job of `target` high samples on its own `x` line. The scheduler grants one requester at a time, counts that requester's high samples, and pulses `done` back to it. It sits between the per-channel control FSMs and the shared counter resource.

---
 rtl/evt_count_sched.sv | 78 +++++++
 tb/tb_evt_count_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_count_sched.sv
// evt_count_sched: round-robin arbiter sharing one x-pulse counting engine among NREQ requesters.
module evt_count_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] x,
  input  logic [CW-1:0]   target,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic [NREQ-1:0] done,
  output logic [CW-1:0]   count
);
  localparam int SW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, COUNT, DONE} state_t;
  state_t        state;
  logic [CW-1:0] tgt;
  logic [SW-1:0] sel, last, nxt;
  int            j;
  // Walk downward so the requester closest after last is the final winner
  always_comb begin
    nxt = '0;
    j = 0;
    for (int i = NREQ; i >= 1; i--) begin
      j = (int'(last) + i) % NREQ;
      if (req[j]) nxt = SW'(j);
    end
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      count <= '0;
      tgt   <= '0;
      sel   <= '0;
      last  <= SW'(NREQ - 1);
    end else begin
      case (state)
        IDLE:
          if (|req) begin
            sel   <= nxt;
            gnt   <= NREQ'(1) << nxt;
            state <= GRANT;
          end
        GRANT: begin
          tgt   <= target;
          count <= '0;
          if (target == '0) begin
            done  <= gnt;
            state <= DONE;
          end else state <= COUNT;
        end
        COUNT:
          if (!req[sel]) begin
            gnt   <= '0;
            last  <= sel;
            state <= IDLE;
          end else if (x[sel]) begin
            count <= count + CW'(1);
            if (count + CW'(1) == tgt) begin
              done  <= gnt;
              state <= DONE;
            end
          end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          last  <= sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_evt_count_sched.sv
// tb_evt_count_sched: directed and randomized job-level checks of the shared counting scheduler.
module tb_evt_count_sched;
  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int OW   = 2 * NREQ + CW + 1;
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] x = '0;
  logic [CW-1:0]   target = '0;
  logic [NREQ-1:0] gnt, done;
  logic            busy;
  logic [CW-1:0]   count;
  int checks = 0;
  int failures = 0;
  int m_last = NREQ - 1;
  int m_cnt = 0;

  evt_count_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .x(x), .target(target),
    .gnt(gnt), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // Winner: first set request bit strictly after the last served requester, wrapping
  function automatic int pick(input logic [NREQ-1:0] r, input int l);
    for (int i = 1; i <= NREQ; i++) if (r[(l + i) % NREQ]) return (l + i) % NREQ;
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  function automatic logic [OW-1:0] obs(input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                                        input logic b, input int c);
    obs = {g, d, b, CW'(c)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [OW-1:0] e;
    rst = 1'b0;
    repeat (2) tick();
    e = obs('0, '0, 1'b0, 0);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL reset got=%h want=%h", {gnt, done, busy, count}, e);
    end
    rst = 1'b1;
    m_last = NREQ - 1;
    m_cnt = 0;
  endtask

  task automatic test_single;
    logic [OW-1:0] e;
    int w;
    w = pick(4'b0001, m_last);
    req = 4'b0001; target = 3; x = 4'b0001;
    tick();
    e = obs(oh(w), '0, 1'b1, m_cnt);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL single_grant got=%h want=%h", {gnt, done, busy, count}, e);
    end
    tick();
    m_cnt = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      e = obs(oh(w), i == 3 ? oh(w) : '0, 1'b1, i);
      checks++;
      if ({gnt, done, busy, count} !== e) begin
        failures++;
        $display("FAIL single_count%0d got=%h want=%h", i, {gnt, done, busy, count}, e);
      end
    end
    req = '0;
    tick();
    m_cnt = 3; m_last = w;
    e = obs('0, '0, 1'b0, m_cnt);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL single_idle got=%h want=%h", {gnt, done, busy, count}, e);
    end
  endtask

  task automatic test_sparse;
    logic [OW-1:0] e;
    int pat[4] = '{1, 0, 0, 1};
    int w, n;
    w = pick(4'b0001, m_last);
    req = 4'b0001; target = 2; x = 4'b0011;
    tick();
    tick();
    m_cnt = 0; n = 0;
    e = obs(oh(w), '0, 1'b1, 0);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL sparse_latch got=%h want=%h", {gnt, done, busy, count}, e);
    end
    for (int i = 0; i < 4; i++) begin
      x = 4'b0010 | NREQ'(pat[i]);
      tick();
      n += pat[i];
      e = obs(oh(w), n == 2 ? oh(w) : '0, 1'b1, n);
      checks++;
      if ({gnt, done, busy, count} !== e) begin
        failures++;
        $display("FAIL sparse_step%0d got=%h want=%h", i, {gnt, done, busy, count}, e);
      end
    end
    req = '0;
    tick();
    m_cnt = 2; m_last = w;
    e = obs('0, '0, 1'b0, m_cnt);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL sparse_idle got=%h want=%h", {gnt, done, busy, count}, e);
    end
  endtask

  task automatic test_round_robin;
    logic [OW-1:0] e;
    int w;
    req = 4'b1111; target = 1; x = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      w = pick(req, m_last);
      tick();
      e = obs(oh(w), '0, 1'b1, m_cnt);
      checks++;
      if ({gnt, done, busy, count} !== e) begin
        failures++;
        $display("FAIL rr_grant%0d got=%h want=%h", j, {gnt, done, busy, count}, e);
      end
      tick();
      tick();
      m_cnt = 1;
      e = obs(oh(w), oh(w), 1'b1, 1);
      checks++;
      if ({gnt, done, busy, count} !== e) begin
        failures++;
        $display("FAIL rr_done%0d got=%h want=%h", j, {gnt, done, busy, count}, e);
      end
      tick();
      m_last = w;
      e = obs('0, '0, 1'b0, 1);
      checks++;
      if ({gnt, done, busy, count} !== e) begin
        failures++;
        $display("FAIL rr_gap%0d got=%h want=%h", j, {gnt, done, busy, count}, e);
      end
    end
    req = '0;
  endtask

  task automatic test_abort;
    logic [OW-1:0] e;
    int w, w2;
    req = 4'b0100; target = 5; x = 4'b0100;
    w = pick(req, m_last);
    tick();
    tick();
    m_cnt = 0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      e = obs(oh(w), '0, 1'b1, i);
      checks++;
      if ({gnt, done, busy, count} !== e) begin
        failures++;
        $display("FAIL abort_count%0d got=%h want=%h", i, {gnt, done, busy, count}, e);
      end
    end
    req = 4'b1000;
    tick();
    m_cnt = 2; m_last = w;
    e = obs('0, '0, 1'b0, 2);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL abort_drop got=%h want=%h", {gnt, done, busy, count}, e);
    end
    req = 4'b1100;
    w2 = pick(req, m_last);
    tick();
    e = obs(oh(w2), '0, 1'b1, 2);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL abort_next got=%h want=%h", {gnt, done, busy, count}, e);
    end
    target = 0;
    tick();
    e = obs(oh(w2), oh(w2), 1'b1, 0);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL abort_next_done got=%h want=%h", {gnt, done, busy, count}, e);
    end
    req = '0;
    tick();
    m_cnt = 0; m_last = w2;
  endtask

  task automatic test_target_zero;
    logic [OW-1:0] e;
    int w;
    req = 4'b0010; target = 0; x = 4'b1111;
    w = pick(req, m_last);
    tick();
    tick();
    e = obs(oh(w), oh(w), 1'b1, 0);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL zero_done got=%h want=%h", {gnt, done, busy, count}, e);
    end
    req = '0;
    tick();
    m_cnt = 0; m_last = w;
    e = obs('0, '0, 1'b0, 0);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL zero_idle got=%h want=%h", {gnt, done, busy, count}, e);
    end
  endtask

  task automatic test_async_reset;
    logic [OW-1:0] e;
    int w;
    req = 4'b1010; target = 7; x = 4'b1010;
    tick();
    tick();
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    m_cnt = 0; m_last = NREQ - 1;
    e = obs('0, '0, 1'b0, 0);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL async_now got=%h want=%h", {gnt, done, busy, count}, e);
    end
    tick();
    #2 rst = 1'b1;
    w = pick(req, m_last);
    tick();
    e = obs(oh(w), '0, 1'b1, 0);
    checks++;
    if ({gnt, done, busy, count} !== e) begin
      failures++;
      $display("FAIL async_regrant got=%h want=%h", {gnt, done, busy, count}, e);
    end
    target = 0;
    tick();
    req = '0;
    tick();
    m_last = w;
  endtask

  task automatic test_random;
    logic [OW-1:0] e;
    logic [NREQ-1:0] r;
    int w, t, ab, n, cyc;
    bit fin;
    for (int j = 0; j < 60; j++) begin
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      t = $urandom_range(0, 6);
      ab = (t > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, t - 1) : -1;
      w = pick(r, m_last);
      req = r; target = CW'(t); x = NREQ'($urandom);
      tick();
      e = obs(oh(w), '0, 1'b1, m_cnt);
      checks++;
      if ({gnt, done, busy, count} !== e) begin
        failures++;
        $display("FAIL rnd_grant%0d got=%h want=%h", j, {gnt, done, busy, count}, e);
      end
      x = NREQ'($urandom);
      tick();
      m_cnt = 0;
      e = obs(oh(w), t == 0 ? oh(w) : '0, 1'b1, 0);
      checks++;
      if ({gnt, done, busy, count} !== e) begin
        failures++;
        $display("FAIL rnd_latch%0d got=%h want=%h", j, {gnt, done, busy, count}, e);
      end
      n = 0; cyc = 0;
      fin = (t == 0);
      if (t == 0) begin
        req = '0;
        tick();
        m_last = w;
      end
      while (!fin && cyc < 64) begin
        cyc++;
        x = NREQ'($urandom);
        if (n == ab) begin
          req = r & ~oh(w);
          tick();
          e = obs('0, '0, 1'b0, n);
          checks++;
          if ({gnt, done, busy, count} !== e) begin
            failures++;
            $display("FAIL rnd_abort%0d got=%h want=%h", j, {gnt, done, busy, count}, e);
          end
          m_cnt = n; m_last = w; fin = 1;
        end else begin
          tick();
          if (x[w]) n++;
          e = obs(oh(w), n == t ? oh(w) : '0, 1'b1, n);
          checks++;
          if ({gnt, done, busy, count} !== e) begin
            failures++;
            $display("FAIL rnd_count%0d got=%h want=%h", j, {gnt, done, busy, count}, e);
          end
          if (n == t) begin
            req = '0;
            tick();
            e = obs('0, '0, 1'b0, t);
            checks++;
            if ({gnt, done, busy, count} !== e) begin
              failures++;
              $display("FAIL rnd_exit%0d got=%h want=%h", j, {gnt, done, busy, count}, e);
            end
            m_cnt = t; m_last = w; fin = 1;
          end
        end
      end
      if (!fin) begin
        checks++;
        failures++;
        $display("FAIL rnd_timeout%0d count=%0d want=%0d", j, count, t);
        req = '0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_cnt = 0; m_last = NREQ - 1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sparse();
    test_round_robin();
    test_abort();
    test_target_zero();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
